// File: rtl/decoder_3to8_strobe.sv
// Queued 3-to-8 one-hot strobe decoder: codes enter a small FIFO and are replayed
// as a one-hot pulse held PULSE_LEN cycles, followed by GAP_LEN forced idle cycles.
module decoder_3to8_strobe #(
  parameter int DEPTH     = 4,
  parameter int PULSE_LEN = 3,
  parameter int GAP_LEN   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_code,
  input  logic                     en,
  output logic [7:0]               out,
  output logic                     out_valid,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int PG_MAX  = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CNT_MAX = (PG_MAX > 2) ? PG_MAX : 2;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = (GAP_LEN > 0) ? CNT_W'(GAP_LEN - 1) : '0;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic logic [7:0] decode(input logic [2:0] code);
    decode = 8'b1 << code;
  endfunction

  logic [2:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             full, empty, push, pop;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       out_q, out_d;
  logic [2:0]       head;

  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);
  assign push  = in_valid && !full;
  assign head  = mem_q[rd_ptr_q];

  // Storage carries data only, so it is left out of the reset domain.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  // en is only consulted at the points where a new code could be popped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        out_d = '0;
        if (!empty && en) begin
          pop     = 1'b1;
          out_d   = decode(head);
          cnt_d   = PULSE_LD;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (GAP_LEN > 0) begin
          out_d   = '0;
          cnt_d   = GAP_LD;
          state_d = GAP;
        end else if (!empty && en) begin
          pop     = 1'b1;
          out_d   = decode(head);
          cnt_d   = PULSE_LD;
          state_d = DRIVE;
        end else begin
          out_d   = '0;
          state_d = IDLE;
        end
      end
      GAP: begin
        out_d = '0;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        out_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = !full;
  assign out       = out_q;
  assign out_valid = |out_q;
  assign busy      = (state_q != IDLE) || !empty;
  assign level     = level_q;

  a_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(out_q));
  a_level  : assert property (@(posedge clk) disable iff (!rst_n) level_q <= FULL_LVL);

endmodule
